// File: rtl/pe_shift_accumulator_if.sv
//------------------------------------------------------------------------------
// Module   : pe_shift_accumulator_if
// Purpose  : Beat-in / result-out bundle for the PE shift accumulator.
//            Input side: valid/ready beat carrying 10 bit-plane tree sums, two
//            compensation sums and frame framing/mode bits.
//            Output side: valid/ready result register with two signed lanes
//            and a one-cycle error pulse.
// Modports : master - producer/consumer side (drives beats, out_ready)
//            slave  - accumulator side (drives in_ready, results, err)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pe_shift_accumulator_if #(
  parameter int ADDER_TREE_OUT_BITWIDTH = 9,
  parameter int ACC_W                   = 32
) ();
  logic                                 in_valid;
  logic                                 in_ready;
  logic                                 in_first;
  logic                                 in_last;
  logic                                 in_signed;
  logic [2:0]                           mode;
  logic [10*ADDER_TREE_OUT_BITWIDTH-1:0] sum;
  logic [2*ADDER_TREE_OUT_BITWIDTH-1:0]  compensation_sum;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [ACC_W-1:0]                     result_lo;
  logic [ACC_W-1:0]                     result_hi;
  logic                                 err;

  modport master (
    output in_valid, in_first, in_last, in_signed, mode, sum, compensation_sum, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, err
  );

  modport slave (
    input  in_valid, in_first, in_last, in_signed, mode, sum, compensation_sum, out_ready,
    output in_ready, out_valid, result_lo, result_hi, err
  );
endinterface

`default_nettype wire

// File: rtl/pe_shift_accumulator.sv
//------------------------------------------------------------------------------
// Module   : pe_shift_accumulator
// Purpose  : Recombines the 10 bit-plane adder-tree sums plus 2 compensation
//            sums into a signed partial product per beat (stage 1), then
//            accumulates the partial products over a frame (stage 2) and
//            presents the dot-product result through a valid/ready register.
//            In 8b mode activations arrive MSB first, so the accumulator is
//            shifted left by one per beat.
// Ports    : clk  - clock
//            rst  - asynchronous active-high reset
//            bus  - pe_shift_accumulator_if.slave (beats in, results out, err)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pe_shift_accumulator #(
  parameter int COLUMN_NUM              = 256,
  parameter int ADDER_TREE_OUT_BITWIDTH = 9,
  parameter int ACC_W                   = 32,
  parameter int MAX_BEATS               = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pe_shift_accumulator_if.slave  bus
);

  localparam int W     = ADDER_TREE_OUT_BITWIDTH;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  localparam logic [2:0]       c_mode_8b      = 3'b000;
  localparam logic [2:0]       c_mode_4b      = 3'b001;
  localparam logic [2:0]       c_mode_1b      = 3'b010;
  localparam logic [2:0]       c_mode_fp      = 3'b100;
  localparam logic [ACC_W-1:0] c_xnor_offset  = ACC_W'(10 * COLUMN_NUM);
  localparam logic [CNT_W-1:0] c_max_beats    = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_mode;
  logic             r_signed;

  // stage 1 (partial product) registers
  logic             r_s1_valid, r_s1_first, r_s1_last, r_s1_signed;
  logic [2:0]       r_s1_mode;
  logic [ACC_W-1:0] r_p_lo, r_p_hi;

  // stage 2 (accumulator) and output registers
  logic [ACC_W-1:0] r_acc_lo, r_acc_hi, r_result_lo, r_result_hi;
  logic             r_out_valid, r_err;

  logic             w_in_ready, w_accept, w_start, w_cont, w_drop, w_restart;
  logic             w_overrun, w_bad_mode, w_ovf, w_frame_signed;
  logic [2:0]       w_frame_mode;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [ACC_W-1:0] w_p_lo, w_p_hi;
  logic [ACC_W-1:0] w_wsum_all, w_wsum_a, w_wsum_b, w_plain, w_comp0, w_comp1;
  logic signed [ACC_W+1:0] w_wide_lo, w_wide_hi;
  logic             w_neg, w_dbl;

  // ---------------------------------------------------------------- handshake
  assign w_in_ready = (r_state != ST_FLUSH) && !((r_state == ST_HOLD) && !bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_start    = w_accept && bus.in_first;
  assign w_cont     = w_accept && !bus.in_first && (r_state == ST_ACCUM);
  assign w_drop     = w_accept && !bus.in_first && (r_state != ST_ACCUM);
  assign w_restart  = w_start && (r_state == ST_ACCUM);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_overrun  = w_cont && !bus.in_last && (w_cnt_inc == c_max_beats);

  // Mode/sign come from the bus only on a frame's first beat, else the latch.
  assign w_frame_mode   = w_start ? bus.mode : r_mode;
  assign w_frame_signed = w_start ? bus.in_signed : r_signed;
  assign w_bad_mode     = w_start && !(bus.mode inside {c_mode_8b, c_mode_4b, c_mode_1b, c_mode_fp});

  // ------------------------------------------------------------ recombination
  always_comb begin
    w_wsum_all = '0;
    w_wsum_a   = '0;
    w_wsum_b   = '0;
    w_plain    = '0;
    w_comp0    = ACC_W'(bus.compensation_sum[W-1:0]);
    w_comp1    = ACC_W'(bus.compensation_sum[2*W-1:W]);
    for (int j = 0; j < 10; j++) begin
      w_wsum_all = w_wsum_all + (ACC_W'(bus.sum[j*W +: W]) << j);
      w_plain    = w_plain + ACC_W'(bus.sum[j*W +: W]);
      if (j < 5) w_wsum_a = w_wsum_a + (ACC_W'(bus.sum[j*W +: W]) << j);
      else       w_wsum_b = w_wsum_b + (ACC_W'(bus.sum[j*W +: W]) << (j - 5));
    end
    w_p_lo = '0;
    w_p_hi = '0;
    case (w_frame_mode)
      c_mode_8b: w_p_lo = w_wsum_all + w_comp0 + (w_comp1 << 1);
      c_mode_4b: begin
        w_p_lo = w_wsum_a + w_comp0;
        w_p_hi = w_wsum_b + w_comp1;
      end
      c_mode_1b: w_p_lo = (w_plain << 1) - c_xnor_offset;
      c_mode_fp: w_p_lo = w_wsum_all + ((w_comp0 - w_comp1) << 10);
      default:   w_p_lo = '0;
    endcase
  end

  // ------------------------------------------------------------- accumulation
  // Two guard bits cover the worst case (acc<<1)+P without wrapping.
  function automatic logic signed [ACC_W+1:0] acc_step(
    input logic [ACC_W-1:0] acc, input logic [ACC_W-1:0] p,
    input logic first, input logic neg, input logic dbl);
    logic signed [ACC_W+1:0] a, x;
    a = {{2{acc[ACC_W-1]}}, acc};
    x = {{2{p[ACC_W-1]}}, p};
    if (first)    return neg ? -x : x;
    else if (dbl) return (a <<< 1) + x;
    else          return a + x;
  endfunction

  function automatic logic is_ovf(input logic signed [ACC_W+1:0] v);
    return !((&v[ACC_W+1:ACC_W-1]) || !(|v[ACC_W+1:ACC_W-1]));
  endfunction

  function automatic logic [ACC_W-1:0] saturate(input logic signed [ACC_W+1:0] v);
    if (!is_ovf(v))       return v[ACC_W-1:0];
    else if (v[ACC_W+1])  return {1'b1, {(ACC_W-1){1'b0}}};
    else                  return {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  assign w_dbl     = (r_s1_mode == c_mode_8b);
  assign w_neg     = w_dbl && r_s1_signed;
  assign w_wide_lo = acc_step(r_acc_lo, r_p_lo, r_s1_first, w_neg, w_dbl);
  assign w_wide_hi = acc_step(r_acc_hi, r_p_hi, r_s1_first, w_neg, w_dbl);
  assign w_ovf     = r_s1_valid && (is_ovf(w_wide_lo) || is_ovf(w_wide_hi));

  // -------------------------------------------------------- FSM and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mode      <= '0;
      r_signed    <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_signed <= 1'b0;
      r_s1_mode   <= '0;
      r_p_lo      <= '0;
      r_p_hi      <= '0;
      r_acc_lo    <= '0;
      r_acc_hi    <= '0;
      r_result_lo <= '0;
      r_result_hi <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // frame control
      if (w_start) begin
        r_cnt    <= CNT_W'(1);
        r_mode   <= bus.mode;
        r_signed <= bus.in_signed;
        r_state  <= bus.in_last ? ST_FLUSH : ST_ACCUM;
      end else begin
        case (r_state)
          ST_ACCUM: if (w_cont) begin
            if (bus.in_last) begin
              r_state <= ST_FLUSH;
            end else if (w_overrun) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_FLUSH: if (r_s1_valid && r_s1_last) r_state <= ST_HOLD;
          ST_HOLD:  if (r_out_valid && bus.out_ready) r_state <= ST_IDLE;
          default:  r_state <= ST_IDLE;
        endcase
      end

      // stage 1: overrun beat is discarded so it never reaches the accumulator
      r_s1_valid  <= w_start || (w_cont && !w_overrun);
      r_s1_first  <= w_start;
      r_s1_last   <= bus.in_last;
      r_s1_mode   <= w_frame_mode;
      r_s1_signed <= w_frame_signed;
      r_p_lo      <= w_p_lo;
      r_p_hi      <= w_p_hi;

      // stage 2
      if (r_s1_valid) begin
        r_acc_lo <= saturate(w_wide_lo);
        r_acc_hi <= saturate(w_wide_hi);
      end
      if (r_s1_valid && r_s1_last) begin
        r_result_lo <= saturate(w_wide_lo);
        r_result_hi <= saturate(w_wide_hi);
        r_out_valid <= 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      r_err <= w_drop || w_restart || w_overrun || w_bad_mode || w_ovf;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result_lo = r_result_lo;
  assign bus.result_hi = r_result_hi;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pe_shift_accumulator.sv
//------------------------------------------------------------------------------
// Module   : tb_pe_shift_accumulator
// Purpose  : Self-checking bench for pe_shift_accumulator: table of directed
//            frames with hand-computed results, plus hand-written sequences
//            for reset, backpressure, restart, overrun, bad mode, saturation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe_shift_accumulator;
  localparam int W     = 9;
  localparam int ACC_W = 32;
  localparam int SW    = 10 * W;
  localparam int CW    = 2 * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_shift_accumulator_if #(.ADDER_TREE_OUT_BITWIDTH(W), .ACC_W(ACC_W)) bus ();

  pe_shift_accumulator #(
    .COLUMN_NUM(256), .ADDER_TREE_OUT_BITWIDTH(W), .ACC_W(ACC_W), .MAX_BEATS(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [2:0]              mode;
    logic                    sgn;
    int                      nb;
    logic [SW-1:0]           s0, s1;
    logic [CW-1:0]           c0, c1;
    logic signed [ACC_W-1:0] lo, hi;
  } vec_t;

  vec_t vecs[11];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   err_cnt  = 0;

  always @(negedge clk) if (bus.err === 1'b1) err_cnt++;

  function automatic logic [SW-1:0] all_sums(input int v);
    logic [SW-1:0] r;
    r = '0;
    for (int j = 0; j < 10; j++) r[j*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [SW-1:0] one_sum(input int j, input int v);
    logic [SW-1:0] r;
    r = '0;
    r[j*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [CW-1:0] comps(input int a, input int b);
    return {W'(b), W'(a)};
  endfunction

  function automatic vec_t mkv(input logic [2:0] m, input logic s, input int nb,
                               input logic [SW-1:0] s0, input logic [CW-1:0] c0,
                               input logic [SW-1:0] s1, input logic [CW-1:0] c1,
                               input int lo, input int hi);
    vec_t v;
    v.mode = m; v.sgn = s; v.nb = nb;
    v.s0 = s0; v.c0 = c0; v.s1 = s1; v.c1 = c1;
    v.lo = lo; v.hi = hi;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drive(input logic f, input logic l, input logic [2:0] m, input logic s,
                       input logic [SW-1:0] sm, input logic [CW-1:0] c);
    bus.in_valid = 1'b1; bus.in_first = f; bus.in_last = l;
    bus.mode = m; bus.in_signed = s; bus.sum = sm; bus.compensation_sum = c;
  endtask

  // Called right after the last beat was driven; returns negedges until out_valid.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) idle_in();
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 20);
  endtask

  // Non-first beats drive inverted mode/sign to show they are ignored; a bubble
  // separates consecutive beats.
  task automatic send_frame(input vec_t v, output int lat);
    for (int b = 0; b < v.nb; b++) begin
      @(negedge clk);
      if (b > 0) begin
        idle_in();
        @(negedge clk);
      end
      drive(b == 0, b == v.nb - 1, (b == 0) ? v.mode : ~v.mode, (b == 0) ? v.sgn : ~v.sgn,
            (b == 0) ? v.s0 : v.s1, (b == 0) ? v.c0 : v.c1);
    end
    wait_out(lat);
  endtask

  initial begin
    int lat, e, seen;
    vec_t v;

    vecs[0]  = mkv(3'b000, 0, 1, all_sums(1), '0, '0, '0, 1023, 0);
    vecs[1]  = mkv(3'b000, 1, 2, one_sum(0,1) | one_sum(1,1), '0, one_sum(0,1), '0, -5, 0);
    vecs[2]  = mkv(3'b001, 0, 1, one_sum(0,2) | one_sum(5,3), comps(1,0), '0, '0, 3, 3);
    vecs[3]  = mkv(3'b010, 0, 1, all_sums(128), '0, '0, '0, 0, 0);
    vecs[4]  = mkv(3'b010, 0, 1, all_sums(256), '0, '0, '0, 2560, 0);
    vecs[5]  = mkv(3'b100, 0, 1, one_sum(0,5), comps(1,3), '0, '0, -2043, 0);
    vecs[6]  = mkv(3'b000, 0, 2, one_sum(0,1) | one_sum(1,1), '0, one_sum(0,1), '0, 7, 0);
    vecs[7]  = mkv(3'b001, 0, 2, one_sum(1,1) | one_sum(6,2), '0, '0, comps(5,7), 7, 11);
    vecs[8]  = mkv(3'b000, 0, 1, '0, comps(10,3), '0, '0, 16, 0);
    vecs[9]  = mkv(3'b010, 0, 1, '0, '0, '0, '0, -2560, 0);
    vecs[10] = mkv(3'b000, 1, 1, one_sum(9,1), '0, '0, '0, -512, 0);

    // reset state
    rst = 1'b1;
    idle_in();
    bus.in_signed = 1'b0; bus.mode = '0; bus.sum = '0; bus.compensation_sum = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result_lo", $signed(bus.result_lo), 0);
    check("rst_result_hi", $signed(bus.result_hi), 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_err", bus.err, 0);
    rst = 1'b0;

    // table-driven frames
    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i], lat);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_result_lo", i), $signed(bus.result_lo), vecs[i].lo);
      check($sformatf("vec%0d_result_hi", i), $signed(bus.result_hi), vecs[i].hi);
    end

    // reset mid-frame
    @(negedge clk); drive(1, 0, 3'b000, 0, all_sums(1), '0);
    @(negedge clk); drive(0, 0, 3'b000, 0, all_sums(1), '0);
    @(negedge clk); idle_in(); rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_result_lo", $signed(bus.result_lo), 0);
    check("midrst_in_ready", bus.in_ready, 1);
    @(negedge clk); rst = 1'b0;
    e = err_cnt;
    @(negedge clk); drive(0, 1, 3'b000, 0, all_sums(1), '0);
    @(negedge clk); idle_in();
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1;
    end
    check("midrst_nonfirst_err", err_cnt - e, 1);
    check("midrst_no_output", seen, 0);

    // backpressure: frame 1 held while frame 2 waits, then both delivered
    bus.out_ready = 1'b0;
    @(negedge clk); drive(1, 1, 3'b000, 0, all_sums(1), '0);
    wait_out(lat);
    check("bp_r1_latency", lat, 2);
    check("bp_r1_value", $signed(bus.result_lo), 1023);
    drive(1, 1, 3'b000, 0, one_sum(0,1) | one_sum(2,1), '0);
    #1 check("bp_in_ready_low", bus.in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_r1_stable", $signed(bus.result_lo), 1023);
      check("bp_r1_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    #1 check("bp_in_ready_high", bus.in_ready, 1);
    wait_out(lat);
    check("bp_r2_latency", lat, 2);
    check("bp_r2_value", $signed(bus.result_lo), 5);

    // in_first mid-frame restarts the frame
    e = err_cnt;
    @(negedge clk); drive(1, 0, 3'b000, 0, one_sum(2,25), '0);
    @(negedge clk); drive(1, 1, 3'b000, 0, one_sum(0,7), '0);
    wait_out(lat);
    check("restart_latency", lat, 2);
    check("restart_value", $signed(bus.result_lo), 7);
    check("restart_err", err_cnt - e, 1);

    // MAX_BEATS reached without in_last
    e = err_cnt;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk); drive(b == 0, 0, 3'b000, 0, one_sum(0,1), '0);
    end
    @(negedge clk); idle_in();
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1;
    end
    check("overrun_err", err_cnt - e, 1);
    check("overrun_no_output", seen, 0);
    v = mkv(3'b000, 0, 1, one_sum(0,9), '0, '0, '0, 9, 0);
    send_frame(v, lat);
    check("post_overrun_value", $signed(bus.result_lo), 9);

    // unsupported mode code
    e = err_cnt;
    v = mkv(3'b011, 0, 1, all_sums(1), '0, '0, '0, 0, 0);
    send_frame(v, lat);
    check("badmode_latency", lat, 2);
    check("badmode_value", $signed(bus.result_lo), 0);
    check("badmode_err", err_cnt - e, 1);

    // positive saturation over a 16-beat 8b frame
    e = err_cnt;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk); drive(b == 0, b == 15, 3'b000, 0, all_sums(511), comps(511, 511));
    end
    wait_out(lat);
    check("sat_latency", lat, 2);
    check("sat_value", $signed(bus.result_lo), 2147483647);
    check("sat_err_seen", (err_cnt > e) ? 1 : 0, 1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
